// File: rtl/bp_me_mesh_edge_endpoint.sv
// East-edge endpoint of the 1-D LCE/CCE chain: strips request headers toward the CCE and injects CCE commands.
// Optional destination check of incoming requests is enabled with `define BP_ME_EDGE_DEST_CHECK_EN.

// Handshake: a beat moves on a side iff valid and ready are both high in the same cycle;
// ready never depends combinationally on the paired valid, and data holds while valid waits for ready.
module bp_me_mesh_edge_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [width_p-1:0] wr_data,
    input  logic               wr_valid,
    input  logic               wr_keep,
    output logic               wr_ready,
    output logic [width_p-1:0] rd_data,
    output logic               rd_valid,
    input  logic               rd_ready
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count;
    logic               push;
    logic               pop;

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready comes only from registered occupancy, so a full buffer stays not-ready even while popping.
    assign wr_ready = (count != cnt_w'(els_p));
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign push     = wr_valid & wr_ready & wr_keep;
    assign pop      = rd_valid & rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < els_p; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module bp_me_mesh_edge_endpoint #(
    parameter int req_payload_width_p = 64,
    parameter int cmd_payload_width_p = 64,
    parameter int x_cord_width_p      = 1,
    parameter int y_cord_width_p      = 1,
    parameter int fifo_els_p          = 2,
    localparam int nw_req = req_payload_width_p + x_cord_width_p + y_cord_width_p,
    localparam int nw_cmd = cmd_payload_width_p + x_cord_width_p + y_cord_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [x_cord_width_p-1:0]      my_x_i,
    input  logic [y_cord_width_p-1:0]      my_y_i,
    input  logic [nw_req+1:0]              req_link_i,
    output logic [nw_req+1:0]              req_link_o,
    input  logic [nw_cmd+1:0]              cmd_link_i,
    output logic [nw_cmd+1:0]              cmd_link_o,
    output logic [req_payload_width_p-1:0] req_o,
    output logic                           req_v_o,
    input  logic                           req_ready_i,
    input  logic [cmd_payload_width_p-1:0] cmd_i,
    input  logic [x_cord_width_p-1:0]      cmd_dest_x_i,
    input  logic [y_cord_width_p-1:0]      cmd_dest_y_i,
    input  logic                           cmd_v_i,
    output logic                           cmd_ready_o,
    output logic                           error_o
);
    localparam int hdr_w = x_cord_width_p + y_cord_width_p;

    // Link layout: {v, ready_and_rev, data}, data = {payload, x, y} with y in the LSBs.
    logic                           req_link_v;
    logic [req_payload_width_p-1:0] req_payload;
    logic [x_cord_width_p-1:0]      req_x;
    logic [y_cord_width_p-1:0]      req_y;
    logic                           cmd_link_ready;

    assign req_link_v     = req_link_i[nw_req+1];
    assign req_payload    = req_link_i[nw_req-1:hdr_w];
    assign req_x          = req_link_i[hdr_w-1:y_cord_width_p];
    assign req_y          = req_link_i[y_cord_width_p-1:0];
    assign cmd_link_ready = cmd_link_i[nw_cmd];

    logic              rx_ready;
    logic              rx_keep;
    logic              tx_valid;
    logic [nw_cmd-1:0] tx_data;
    logic [nw_cmd-1:0] cmd_packet;

    assign cmd_packet = {cmd_i, cmd_dest_x_i, cmd_dest_y_i};

    bp_me_mesh_edge_fifo #(
        .width_p (req_payload_width_p),
        .els_p   (fifo_els_p)
    ) rx_fifo (
        .clk      (clk_i),
        .rst      (reset_i),
        .wr_data  (req_payload),
        .wr_valid (req_link_v),
        .wr_keep  (rx_keep),
        .wr_ready (rx_ready),
        .rd_data  (req_o),
        .rd_valid (req_v_o),
        .rd_ready (req_ready_i)
    );

    bp_me_mesh_edge_fifo #(
        .width_p (nw_cmd),
        .els_p   (fifo_els_p)
    ) tx_fifo (
        .clk      (clk_i),
        .rst      (reset_i),
        .wr_data  (cmd_packet),
        .wr_valid (cmd_v_i),
        .wr_keep  (1'b1),
        .wr_ready (cmd_ready_o),
        .rd_data  (tx_data),
        .rd_valid (tx_valid),
        .rd_ready (cmd_link_ready)
    );

    assign req_link_o = {1'b0, rx_ready, {nw_req{1'b0}}};
    assign cmd_link_o = {tx_valid, 1'b0, tx_data};

`ifdef BP_ME_EDGE_DEST_CHECK_EN
    // A misrouted request is still acknowledged so the chain drains, but it is dropped and flagged.
    logic misrouted;
    logic error_r;

    assign misrouted = ({req_x, req_y} != {my_x_i, my_y_i});
    assign rx_keep   = ~misrouted;
    assign error_o   = error_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_r <= 1'b0;
        end else if (req_link_v & rx_ready & misrouted) begin
            error_r <= 1'b1;
        end
    end

    logic unused_link_bits;
    assign unused_link_bits = ^{req_link_i[nw_req], cmd_link_i[nw_cmd+1], cmd_link_i[nw_cmd-1:0]};
`else
    assign rx_keep = 1'b1;
    assign error_o = 1'b0;

    logic unused_link_bits;
    assign unused_link_bits = ^{req_link_i[nw_req], cmd_link_i[nw_cmd+1], cmd_link_i[nw_cmd-1:0],
                                req_x, req_y, my_x_i, my_y_i};
`endif
endmodule

// File: tb/tb_bp_me_mesh_edge_endpoint.sv
// Self-checking bench for bp_me_mesh_edge_endpoint; queue-based reference model of both directions.
// Adds a destination-check scenario when BP_ME_EDGE_DEST_CHECK_EN is defined.
module tb_bp_me_mesh_edge_endpoint;
    localparam int RW    = 64;
    localparam int CW    = 64;
    localparam int DEPTH = 2;
    localparam int NWR   = RW + 2;
    localparam int NWC   = CW + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [0:0]     my_x;
    logic [0:0]     my_y;
    logic [NWR+1:0] req_link_i;
    logic [NWR+1:0] req_link_o;
    logic [NWC+1:0] cmd_link_i;
    logic [NWC+1:0] cmd_link_o;
    logic [RW-1:0]  req_o;
    logic           req_v_o;
    logic           req_ready_i;
    logic [CW-1:0]  cmd_i;
    logic [0:0]     cmd_dest_x_i;
    logic [0:0]     cmd_dest_y_i;
    logic           cmd_v_i;
    logic           cmd_ready_o;
    logic           error_o;

    int errors = 0;
    int checks = 0;

    logic [RW-1:0]  exp_q[$];
    logic [NWC-1:0] exp_cmd_q[$];

    wire            req_link_ready = req_link_o[NWR];
    wire            cmd_link_v     = cmd_link_o[NWC+1];
    wire [NWC-1:0]  cmd_link_data  = cmd_link_o[NWC-1:0];

    bp_me_mesh_edge_endpoint dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .my_x_i       (my_x),
        .my_y_i       (my_y),
        .req_link_i   (req_link_i),
        .req_link_o   (req_link_o),
        .cmd_link_i   (cmd_link_i),
        .cmd_link_o   (cmd_link_o),
        .req_o        (req_o),
        .req_v_o      (req_v_o),
        .req_ready_i  (req_ready_i),
        .cmd_i        (cmd_i),
        .cmd_dest_x_i (cmd_dest_x_i),
        .cmd_dest_y_i (cmd_dest_y_i),
        .cmd_v_i      (cmd_v_i),
        .cmd_ready_o  (cmd_ready_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    task automatic drive_req(input logic v, input logic [RW-1:0] p, input logic [0:0] x, input logic [0:0] y);
        req_link_i = {v, 1'b0, p, x, y};
    endtask

    task automatic drive_cmd(input logic v, input logic [CW-1:0] c, input logic [0:0] x, input logic [0:0] y);
        cmd_v_i      = v;
        cmd_i        = c;
        cmd_dest_x_i = x;
        cmd_dest_y_i = y;
    endtask

    task automatic drive_link_ready(input logic r);
        cmd_link_i = {1'b0, r, {NWC{1'b0}}};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_req(1'b0, '0, 1'b0, 1'b0);
        drive_cmd(1'b0, '0, 1'b0, 1'b0);
        drive_link_ready(1'b0);
        req_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_v_o !== 1'b0) begin errors++; $display("FAIL reset_req_v: got %b expected 0", req_v_o); end
        checks++; if (cmd_link_v !== 1'b0) begin errors++; $display("FAIL reset_cmd_v: got %b expected 0", cmd_link_v); end
        checks++; if (req_link_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_link_ready); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error_o); end
        checks++; if ({req_link_o[NWR+1], req_link_o[NWR-1:0]} !== '0) begin errors++; $display("FAIL reset_req_link_unused: got %h expected 0", req_link_o); end
        checks++; if (cmd_link_o[NWC] !== 1'b0) begin errors++; $display("FAIL reset_cmd_link_unused: got %b expected 0", cmd_link_o[NWC]); end
    endtask

    task automatic test_single_req();
        my_x = 1'b1; my_y = 1'b1;
        req_ready_i = 1'b1;
        drive_req(1'b1, 64'hA5, 1'b1, 1'b1);
        checks++; if (req_v_o !== 1'b0) begin errors++; $display("FAIL single_pre_v: got %b expected 0", req_v_o); end
        @(negedge clk);
        drive_req(1'b0, '0, 1'b0, 1'b0);
        checks++; if (req_v_o !== 1'b1) begin errors++; $display("FAIL single_v: got %b expected 1", req_v_o); end
        checks++; if (req_o !== 64'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", req_o); end
        @(negedge clk);
        checks++; if (req_v_o !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", req_v_o); end
    endtask

    task automatic test_req_backpressure();
        logic [RW-1:0] p [3];
        for (int i = 0; i < 3; i++) p[i] = {$urandom, $urandom};
        req_ready_i = 1'b0;
        drive_req(1'b1, p[0], my_x, my_y);
        checks++; if (req_link_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b expected 1", req_link_ready); end
        @(negedge clk);
        drive_req(1'b1, p[1], my_x, my_y);
        checks++; if (req_link_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", req_link_ready); end
        checks++; if (req_o !== p[0]) begin errors++; $display("FAIL bp_head0: got %h expected %h", req_o, p[0]); end
        @(negedge clk);
        drive_req(1'b1, p[2], my_x, my_y);
        checks++; if (req_link_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", req_link_ready); end
        @(negedge clk);
        req_ready_i = 1'b1;
        checks++; if (req_link_ready !== 1'b0) begin errors++; $display("FAIL bp_no_bypass: got %b expected 0", req_link_ready); end
        checks++; if (req_o !== p[0]) begin errors++; $display("FAIL bp_order0: got %h expected %h", req_o, p[0]); end
        @(negedge clk);
        checks++; if (req_link_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen: got %b expected 1", req_link_ready); end
        checks++; if (req_o !== p[1]) begin errors++; $display("FAIL bp_order1: got %h expected %h", req_o, p[1]); end
        @(negedge clk);
        drive_req(1'b0, '0, 1'b0, 1'b0);
        checks++; if (req_v_o !== 1'b1 || req_o !== p[2]) begin errors++; $display("FAIL bp_order2: got v=%b %h expected v=1 %h", req_v_o, req_o, p[2]); end
        @(negedge clk);
        checks++; if (req_v_o !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", req_v_o); end
        req_ready_i = 1'b0;
    endtask

    task automatic test_cmd_hold();
        logic [NWC-1:0] exp_pkt;
        exp_pkt = {64'h5A, 1'b0, 1'b1};
        drive_link_ready(1'b0);
        drive_cmd(1'b1, 64'h5A, 1'b0, 1'b1);
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL hold_cmd_ready: got %b expected 1", cmd_ready_o); end
        @(negedge clk);
        drive_cmd(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_link_v !== 1'b1 || cmd_link_data !== exp_pkt) begin
                errors++; $display("FAIL hold_stable[%0d]: got v=%b %h expected v=1 %h", i, cmd_link_v, cmd_link_data, exp_pkt);
            end
            @(negedge clk);
        end
        drive_link_ready(1'b1);
        checks++; if (cmd_link_v !== 1'b1 || cmd_link_data !== exp_pkt) begin errors++; $display("FAIL hold_at_ready: got v=%b %h expected v=1 %h", cmd_link_v, cmd_link_data, exp_pkt); end
        @(negedge clk);
        drive_link_ready(1'b0);
        checks++; if (cmd_link_v !== 1'b0) begin errors++; $display("FAIL hold_transferred: got %b expected 0", cmd_link_v); end
    endtask

    // Cycle-level reference: each direction is a bounded queue of DEPTH entries.
    task automatic test_stream(input int n, input bit random_mode);
        logic          rv, rr, cv, lr;
        logic [RW-1:0] rp;
        logic [CW-1:0] cp;
        logic [0:0]    dx, dy;
        bit            r_in, r_out, c_in, c_out;
        exp_q.delete();
        exp_cmd_q.delete();
        for (int i = 0; i < n + DEPTH + 2; i++) begin
            checks++; if (req_v_o !== (exp_q.size() != 0)) begin errors++; $display("FAIL stream_req_v[%0d]: got %b expected %b", i, req_v_o, exp_q.size() != 0); end
            checks++; if (req_link_ready !== (exp_q.size() < DEPTH)) begin errors++; $display("FAIL stream_req_ready[%0d]: got %b expected %b", i, req_link_ready, exp_q.size() < DEPTH); end
            if (exp_q.size() != 0) begin
                checks++; if (req_o !== exp_q[0]) begin errors++; $display("FAIL stream_req_data[%0d]: got %h expected %h", i, req_o, exp_q[0]); end
            end
            checks++; if (cmd_link_v !== (exp_cmd_q.size() != 0)) begin errors++; $display("FAIL stream_cmd_v[%0d]: got %b expected %b", i, cmd_link_v, exp_cmd_q.size() != 0); end
            checks++; if (cmd_ready_o !== (exp_cmd_q.size() < DEPTH)) begin errors++; $display("FAIL stream_cmd_ready[%0d]: got %b expected %b", i, cmd_ready_o, exp_cmd_q.size() < DEPTH); end
            if (exp_cmd_q.size() != 0) begin
                checks++; if (cmd_link_data !== exp_cmd_q[0]) begin errors++; $display("FAIL stream_cmd_data[%0d]: got %h expected %h", i, cmd_link_data, exp_cmd_q[0]); end
            end
            if (i >= n) begin
                rv = 1'b0; rr = 1'b1; cv = 1'b0; lr = 1'b1;
            end else if (random_mode) begin
                rv = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
                cv = 1'($urandom_range(0, 1)); lr = 1'($urandom_range(0, 1));
            end else begin
                rv = 1'b1; rr = 1'b1; cv = 1'b1; lr = 1'b1;
            end
            rp = {$urandom, $urandom};
            cp = {$urandom, $urandom};
            dx = 1'($urandom_range(0, 1));
            dy = 1'($urandom_range(0, 1));
            drive_req(rv, rp, my_x, my_y);
            req_ready_i = rr;
            drive_cmd(cv, cp, dx, dy);
            drive_link_ready(lr);
            r_in  = rv && (exp_q.size() < DEPTH);
            r_out = rr && (exp_q.size() != 0);
            c_in  = cv && (exp_cmd_q.size() < DEPTH);
            c_out = lr && (exp_cmd_q.size() != 0);
            if (r_out) void'(exp_q.pop_front());
            if (r_in) exp_q.push_back(rp);
            if (c_out) void'(exp_cmd_q.pop_front());
            if (c_in) exp_cmd_q.push_back({cp, dx, dy});
            @(negedge clk);
        end
        req_ready_i = 1'b0;
        drive_link_ready(1'b0);
    endtask

    task automatic test_reset_midflight();
        req_ready_i = 1'b0;
        drive_link_ready(1'b0);
        drive_req(1'b1, 64'h1234, my_x, my_y);
        drive_cmd(1'b1, 64'h5678, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        drive_req(1'b0, '0, 1'b0, 1'b0);
        drive_cmd(1'b0, '0, 1'b0, 1'b0);
        checks++; if (req_v_o !== 1'b1 || cmd_link_v !== 1'b1) begin errors++; $display("FAIL mid_filled: got req_v=%b cmd_v=%b expected 1 1", req_v_o, cmd_link_v); end
        #2 rst = 1'b1;
        #1;
        checks++; if (req_v_o !== 1'b0 || cmd_link_v !== 1'b0) begin errors++; $display("FAIL mid_async_v: got req_v=%b cmd_v=%b expected 0 0", req_v_o, cmd_link_v); end
        checks++; if (req_link_ready !== 1'b1 || cmd_ready_o !== 1'b1) begin errors++; $display("FAIL mid_async_ready: got %b %b expected 1 1", req_link_ready, cmd_ready_o); end
        @(negedge clk);
        rst = 1'b0;
        req_ready_i = 1'b1;
        drive_link_ready(1'b1);
        @(negedge clk);
        checks++; if (req_v_o !== 1'b0 || cmd_link_v !== 1'b0) begin errors++; $display("FAIL mid_discarded: got req_v=%b cmd_v=%b expected 0 0", req_v_o, cmd_link_v); end
        req_ready_i = 1'b0;
        drive_link_ready(1'b0);
    endtask

`ifdef BP_ME_EDGE_DEST_CHECK_EN
    task automatic test_dest_check();
        do_reset();
        my_x = 1'b1; my_y = 1'b1;
        req_ready_i = 1'b1;
        drive_req(1'b1, 64'h77, 1'b0, 1'b1);
        checks++; if (req_link_ready !== 1'b1) begin errors++; $display("FAIL dest_ready: got %b expected 1", req_link_ready); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL dest_err_before: got %b expected 0", error_o); end
        @(negedge clk);
        drive_req(1'b0, '0, 1'b0, 1'b0);
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL dest_err_set: got %b expected 1", error_o); end
        checks++; if (req_v_o !== 1'b0) begin errors++; $display("FAIL dest_dropped: got %b expected 0", req_v_o); end
        drive_req(1'b1, 64'h99, 1'b1, 1'b1);
        @(negedge clk);
        drive_req(1'b0, '0, 1'b0, 1'b0);
        checks++; if (req_v_o !== 1'b1 || req_o !== 64'h99) begin errors++; $display("FAIL dest_good_pkt: got v=%b %h expected v=1 99", req_v_o, req_o); end
        repeat (3) @(negedge clk);
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL dest_err_sticky: got %b expected 1", error_o); end
        do_reset();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL dest_err_cleared: got %b expected 0", error_o); end
    endtask
`else
    task automatic test_dest_check();
        do_reset();
        my_x = 1'b1; my_y = 1'b1;
        req_ready_i = 1'b1;
        drive_req(1'b1, 64'h77, 1'b0, 1'b1);
        @(negedge clk);
        drive_req(1'b0, '0, 1'b0, 1'b0);
        checks++; if (req_v_o !== 1'b1 || req_o !== 64'h77) begin errors++; $display("FAIL nodest_delivered: got v=%b %h expected v=1 77", req_v_o, req_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL nodest_error: got %b expected 0", error_o); end
        req_ready_i = 1'b0;
    endtask
`endif

    initial begin
        my_x = 1'b1;
        my_y = 1'b1;
        test_reset();
        test_single_req();
        test_req_backpressure();
        test_cmd_hold();
        test_stream(100, 1'b0);
        test_stream(300, 1'b1);
        test_reset_midflight();
        test_dest_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
